// File: rtl/axis_pkg.sv
// Shared constants, FSM encoding and packed-beat width helper
// for the AXI-Stream packet FIFO.
package axis_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ID_W   = 8;
  localparam int DEF_DEST_W = 8;
  localparam int DEF_USER_W = 1;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DROP
  } fsm_t;

  function automatic int beat_w(
    input int data_w,
    input int id_w,
    input int dest_w,
    input int user_w
  );
    return data_w + data_w / 8 + 1 + id_w + dest_w + user_w;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage: one write port, combinational read, no reset.
// Contents survive reset; only the pointers are cleared.
module axis_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO: plain beat FIFO or store-and-forward with
// oversize-packet drop, selected by PKT_MODE.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ID_W     = DEF_ID_W,
  parameter int DEST_W   = DEF_DEST_W,
  parameter int USER_W   = DEF_USER_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PKT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic [DATA_W/8-1:0]      s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [ID_W-1:0]          s_axis_tid,
  input  logic [DEST_W-1:0]        s_axis_tdest,
  input  logic [USER_W-1:0]        s_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [DATA_W/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic [DEST_W-1:0]        m_axis_tdest,
  output logic [USER_W-1:0]        m_axis_tuser,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = beat_w(DATA_W, ID_W, DEST_W, USER_W);
  localparam bit PM = (PKT_MODE != 0);

  logic [PW-1:0] wr, wr_c, rd, inflight, pkts;
  logic [BW-1:0] wdata, rdata;
  logic          full, s_fire, m_fire, we;
  logic          drop_now, commit, pop_last;
  fsm_t          state, state_nxt;

  // wr runs ahead of wr_c by the in-flight packet in packet mode
  assign inflight = wr - wr_c;
  assign full     = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign drop_now = PM && (state == ST_FILL) && (inflight == PW'(DEPTH));

  assign s_axis_tready = !rst && (!full || (PM && state == ST_DROP));
  assign m_axis_tvalid = !rst && (PM ? (pkts != '0) : (count != '0));
  assign count         = wr_c - rd;
  assign pkt_drop      = !rst && drop_now;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign m_fire   = m_axis_tvalid && m_axis_tready;
  assign we       = s_fire && !(PM && state == ST_DROP);
  assign commit   = we && (!PM || s_axis_tlast);
  assign pop_last = m_fire && m_axis_tlast;

  assign wdata = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                  s_axis_tid, s_axis_tdest, s_axis_tuser};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
          m_axis_tid, m_axis_tdest, m_axis_tuser} = rdata;

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      wr_c  <= '0;
      rd    <= '0;
      pkts  <= '0;
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
      if (m_fire) rd <= rd + PW'(1);
      if (drop_now) wr <= wr_c;
      else if (we) wr <= wr + PW'(1);
      if (commit) wr_c <= wr + PW'(1);
      if (PM) begin
        if (commit && !pop_last) pkts <= pkts + PW'(1);
        else if (!commit && pop_last) pkts <= pkts - PW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (we && !s_axis_tlast) state_nxt = ST_FILL;
      ST_FILL: begin
        if (drop_now) state_nxt = ST_DROP;
        else if (we && s_axis_tlast) state_nxt = ST_IDLE;
      end
      ST_DROP: if (s_fire && s_axis_tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!PM) state_nxt = ST_IDLE;
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one instance per mode, directed cases
// plus randomized traffic against a queue-based packet model.
module tb_axis_pkt_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [0:0]  user;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        sv   [2];
  logic        srdy [2];
  beat_t       sb   [2];
  logic        mv   [2];
  logic        mrdy [2];
  logic [63:0] md   [2];
  logic [7:0]  mk   [2];
  logic        ml   [2];
  logic [7:0]  mi   [2];
  logic [7:0]  mdst [2];
  logic [0:0]  mu   [2];
  logic [4:0]  cnt  [2];
  logic        drop [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_pkt_fifo #(
      .DATA_W   (64),
      .ID_W     (8),
      .DEST_W   (8),
      .USER_W   (1),
      .DEPTH    (DEPTH),
      .PKT_MODE (g)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (sv[g]),
      .s_axis_tready (srdy[g]),
      .s_axis_tdata  (sb[g].data),
      .s_axis_tkeep  (sb[g].keep),
      .s_axis_tlast  (sb[g].last),
      .s_axis_tid    (sb[g].id),
      .s_axis_tdest  (sb[g].dest),
      .s_axis_tuser  (sb[g].user),
      .m_axis_tvalid (mv[g]),
      .m_axis_tready (mrdy[g]),
      .m_axis_tdata  (md[g]),
      .m_axis_tkeep  (mk[g]),
      .m_axis_tlast  (ml[g]),
      .m_axis_tid    (mi[g]),
      .m_axis_tdest  (mdst[g]),
      .m_axis_tuser  (mu[g]),
      .count         (cnt[g]),
      .pkt_drop      (drop[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: delivered beats, open packet, drop phase
  // phase 0 normal, 1 drop pulse due, 2 discarding to tlast
  beat_t exp_q [$];
  beat_t pkt_q [$];
  int    phase = 0;
  int    drops_seen = 0;
  int    drops_exp = 0;
  int    m_beats = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = 8'($urandom);
    b.last = last;
    b.id   = 8'($urandom);
    b.dest = 8'($urandom);
    b.user = 1'($urandom);
    return b;
  endfunction

  function automatic beat_t out_beat(input int m);
    beat_t b;
    b.data = md[m];
    b.keep = mk[m];
    b.last = ml[m];
    b.id   = mi[m];
    b.dest = mdst[m];
    b.user = mu[m];
    return b;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pkt_q.delete();
    phase = 0;
  endtask

  task automatic model_push(input int m, input beat_t b);
    if (m == 0) begin
      exp_q.push_back(b);
    end else begin
      if (phase == 0) pkt_q.push_back(b);
      if (b.last) begin
        if (phase == 0) foreach (pkt_q[k]) exp_q.push_back(pkt_q[k]);
        else drops_exp++;
        pkt_q.delete();
        phase = 0;
      end else if (phase == 0 && pkt_q.size() == DEPTH) begin
        phase = 1;
      end
    end
  endtask

  task automatic step(input int m, output bit acc);
    bit rd;
    bit exp_rdy;
    @(negedge clk);
    check("count", 128'(cnt[m]), 128'(exp_q.size()));
    check("m_tvalid", 128'(mv[m]), 128'(exp_q.size() != 0));
    check("pkt_drop", 128'(drop[m]), 128'(phase == 1));
    exp_rdy = (phase == 2) ||
              (phase == 0 && exp_q.size() + pkt_q.size() < DEPTH);
    check("s_tready", 128'(srdy[m]), 128'(exp_rdy));
    if (drop[m]) drops_seen++;
    if (phase == 1) phase = 2;
    acc = sv[m] && srdy[m];
    rd  = mv[m] && mrdy[m];
    if (rd) begin
      m_beats++;
      if (exp_q.size() == 0) check("m_extra", 128'(1), 128'(0));
      else check("m_beat", 128'(out_beat(m)), 128'(exp_q.pop_front()));
    end
    if (acc) model_push(m, sb[m]);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int m, input int len, input bit term);
    beat_t b;
    bit    acc;
    int    g;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(term && (i == len - 1));
      acc = 1'b0;
      g = 0;
      while (!acc && g < 100) begin
        sb[m] = b;
        sv[m] = 1'b1;
        step(m, acc);
        g++;
      end
      if (!acc) check("send_timeout", 128'(acc), 128'(1));
    end
    sv[m] = 1'b0;
  endtask

  task automatic drain(input int m);
    bit acc;
    int g = 0;
    sv[m]   = 1'b0;
    mrdy[m] = 1'b1;
    while (exp_q.size() != 0 && g < 200) begin
      step(m, acc);
      g++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    check("drain_count", 128'(cnt[m]), 128'(0));
  endtask

  task automatic run_random(input int m, input int nbeats);
    int    sent = 0;
    int    left = 0;
    int    g = 0;
    bit    pend = 1'b0;
    bit    acc;
    beat_t b;
    while ((sent < nbeats || left != 0 || pend) && g < 60000) begin
      if (!pend) begin
        if (left == 0) left = $urandom_range(1, 20);
        b = rand_beat(left == 1);
        left--;
        pend = 1'b1;
      end
      sb[m]   = b;
      sv[m]   = ($urandom_range(0, 3) != 0);
      mrdy[m] = ($urandom_range(0, 3) != 0);
      step(m, acc);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      g++;
    end
    check("rand_done", 128'(g < 60000), 128'(1));
    drain(m);
  endtask

  int d0;
  int b0;
  bit acc;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i]   = 1'b0;
      mrdy[i] = 1'b0;
      sb[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_count", 128'(cnt[i]), 128'(0));
      check("rst_mvalid", 128'(mv[i]), 128'(0));
      check("rst_sready", 128'(srdy[i]), 128'(0));
      check("rst_drop", 128'(drop[i]), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sready0", 128'(srdy[0]), 128'(1));
    check("post_rst_sready1", 128'(srdy[1]), 128'(1));
    @(posedge clk);
    #1;

    // beat mode: fill to full, then drain in order
    mrdy[0] = 1'b0;
    send(0, DEPTH, 1'b1);
    check("t038_count", 128'(cnt[0]), 128'(DEPTH));
    check("t038_sready", 128'(srdy[0]), 128'(0));
    drain(0);

    // beat mode: streaming keeps exactly one beat resident
    mrdy[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sb[0] = rand_beat(i == 19);
      sv[0] = 1'b1;
      step(0, acc);
      check("t039_count", 128'(cnt[0]), 128'(1));
    end
    drain(0);

    // packet mode: held until tlast, then back-to-back
    mrdy[1] = 1'b1;
    b0 = m_beats;
    send(1, 5, 1'b1);
    check("t040_early", 128'(m_beats - b0), 128'(0));
    for (int i = 0; i < 5; i++) step(1, acc);
    check("t040_b2b", 128'(m_beats - b0), 128'(5));
    drain(1);

    // packet mode: oversize packet dropped, next one intact
    mrdy[1] = 1'b0;
    d0 = drops_seen;
    send(1, 20, 1'b1);
    check("t041_drops", 128'(drops_seen - d0), 128'(1));
    check("t041_count", 128'(cnt[1]), 128'(0));
    mrdy[1] = 1'b1;
    b0 = m_beats;
    send(1, 3, 1'b1);
    drain(1);
    check("t041_next", 128'(m_beats - b0), 128'(3));

    // reset with a committed packet and a partial one stored
    mrdy[1] = 1'b0;
    send(1, 3, 1'b1);
    send(1, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t042_rst_sready", 128'(srdy[1]), 128'(0));
    check("t042_rst_mvalid", 128'(mv[1]), 128'(0));
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("t042_count", 128'(cnt[1]), 128'(0));
    check("t042_mvalid", 128'(mv[1]), 128'(0));
    check("t042_sready", 128'(srdy[1]), 128'(1));
    @(posedge clk);
    #1;
    mrdy[1] = 1'b1;
    b0 = m_beats;
    send(1, 4, 1'b1);
    drain(1);
    check("t042_next", 128'(m_beats - b0), 128'(4));

    run_random(0, 10000);
    run_random(1, 10000);
    check("drops_total", 128'(drops_seen), 128'(drops_exp));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64: tdata width, a multiple of 8.
REQ-002 SHALL have parameter ID_W, default 8: tid width.
REQ-003 SHALL have parameter DEST_W, default 8: tdest width.
REQ-004 SHALL have parameter USER_W, default 1: tuser width.
REQ-005 SHALL have parameter DEPTH, default 16: beat capacity, a power of two, at least 2.
REQ-006 SHALL have parameter PKT_MODE, default 0: 0 = beat FIFO; 1 = store-and-forward.
REQ-007 Ports SHALL be: clk  in  1  sole clock; all logic on the rising edge.
REQ-008 Ports SHALL be: rst  in  1  synchronous, active-high reset.
REQ-009 Ports SHALL be: s_axis_tvalid  in  1  slave beat valid.
REQ-010 Ports SHALL be: s_axis_tready  out  1  slave beat ready.
REQ-011 Ports SHALL be: s_axis_tdata  in  DATA_W  slave data.
REQ-012 Ports SHALL be: s_axis_tkeep  in  DATA_W/8  slave byte qualifiers.
REQ-013 Ports SHALL be: s_axis_tlast  in  1  slave end of packet.
REQ-014 Ports SHALL be: s_axis_tid / s_axis_tdest / s_axis_tuser  in  ID_W / DEST_W / USER_W  slave sideband.
REQ-015 Ports SHALL be: m_axis_tvalid  out  1  master beat valid.
REQ-016 Ports SHALL be: m_axis_tready  in  1  master beat ready.
REQ-017 Ports SHALL be: m_axis_tdata/tkeep/tlast/tid/tdest/tuser  out  same widths as the s_axis counterparts  master payload.
REQ-018 Ports SHALL be: count  out  $clog2(DEPTH)+1  beats currently stored.
REQ-019 Ports SHALL be: pkt_drop  out  1  one-cycle pulse when an oversize packet is discarded.

Function
REQ-020 Beat transfer on either port SHALL occur only in a cycle where tvalid && tready.
REQ-021 All payload fields (tdata, tkeep, tlast, tid, tdest, tuser) SHALL be stored as one packed word and emerge unchanged, in order.
REQ-022 s_axis_tready SHALL be 1 when count < DEPTH, and also while in DROP state.
REQ-023 In PKT_MODE=0, m_axis_tvalid SHALL be 1 when count > 0; a beat written in cycle N is presentable in cycle N+1.
REQ-024 In PKT_MODE=1, m_axis_tvalid SHALL be 1 only when the committed-packet counter > 0; the counter increments on writing a tlast beat and decrements on reading a tlast beat.
REQ-025 In PKT_MODE=1, writes SHALL advance a speculative write pointer; on the tlast write, the committed pointer is set to the new speculative value.
REQ-026 In PKT_MODE=1, the read side SHALL see only committed data.
REQ-027 In PKT_MODE=1, FSM states SHALL be IDLE, FILL and DROP.
  - IDLE to FILL: on an accepted non-last beat.
  - FILL to IDLE: on an accepted tlast beat.
  - FILL to DROP: when the FIFO is full and the in-flight packet length equals DEPTH without tlast.
REQ-028 On entering DROP, the speculative pointer SHALL rewind to the committed pointer and pkt_drop SHALL pulse for one cycle.
REQ-029 In DROP, beats SHALL be accepted and discarded until tlast; the accepted tlast beat returns the FSM to IDLE.
REQ-030 If the FIFO is full with a shorter partial packet in flight, s_axis_tready SHALL stay 0 until reads free space; no drop occurs.
REQ-031 A simultaneous read and write SHALL leave count unchanged; a write while full (DROP excepted) SHALL never occur.
REQ-032 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - Full = MSBs differ and LSBs equal.
  - count = wr_committed - rd for PKT_MODE=1 (speculative occupancy gates tready); wr - rd for PKT_MODE=0.
REQ-033 m_axis payload SHALL hold stable while m_axis_tvalid && !m_axis_tready.

Reset
REQ-034 While rst=1, at the clock edge: pointers, count, packet counter = 0; FSM = IDLE; m_axis_tvalid = 0; pkt_drop = 0; s_axis_tready = 0.
REQ-035 Reset mid-packet SHALL discard all stored and partial data; storage contents are not cleared; s_axis_tready = 1 on the first cycle after rst deasserts.

Structure
REQ-036 axis_pkg SHALL hold the default width constants and a function beat_w(DATA_W, ID_W, DEST_W, USER_W) returning the packed word width.
REQ-037 Storage SHALL be one sub-module, axis_fifo_mem: DEPTH x beat_w, one write port, combinational read, no reset.

Verification
REQ-038 PKT_MODE=0, DEPTH=16: write 16 beats with m_axis_tready=0 -> count=16, s_axis_tready=0; drain -> data and sideband in order, count=0.
REQ-039 PKT_MODE=0: continuous write and read with m_axis_tready=1 -> one beat per cycle, count stays 1, latency 1 cycle.
REQ-040 PKT_MODE=1: write a 5-beat packet -> m_axis_tvalid stays 0 until the cycle after the tlast write, then 5 beats emerge back-to-back.
REQ-041 PKT_MODE=1, DEPTH=16: send a 20-beat packet with m_axis_tready=0 -> pkt_drop pulses once after beat 16; beats 17-20 are accepted; count=0; the next 3-beat packet is delivered intact.
REQ-042 Assert rst in the middle of a 4-beat packet write -> next cycle count=0, m_axis_tvalid=0; a following packet is delivered correctly.
REQ-043 Random valid/ready toggling over 10k beats, both modes -> output stream equals input stream minus dropped packets; no beat duplicated or lost.
